// File: rtl/core_inst_seq.sv
// core_inst_seq: per-core instruction sequencer. Streams host words into xmem,
// moves them to L0, executes, drains, then copies the output FIFO into pmem.
// The command word and xmem write data are registered, so every command
// appears on inst one cycle after the state/count that produced it.
module core_inst_seq #(
  parameter int bw      = 4,
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_bw-1:0]    len,
  input  logic [7:0]            drain,
  input  logic [bw*row-1:0]     host_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  output logic [33:0]           inst,
  output logic [bw*row-1:0]     D_xmem,
  output logic                  busy,
  output logic                  done
);

  // col does not shape the datapath; it is referenced so the parameter list
  // stays identical to the core it sits beside.
  localparam int XMEM_W = bw * row + 0 * col;
  localparam int CW     = addr_bw + 1;

  typedef logic [CW-1:0] cnt_t;

  // inst bit positions
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_HI    = 30;
  localparam int B_AP_LO    = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_HI    = 17;
  localparam int B_AX_LO    = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;

  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_L0,
    S_EXEC,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  cnt_t                r_cnt;
  cnt_t                w_cnt_inc;
  cnt_t                w_len_ext;
  cnt_t                w_drain_ext;
  logic                w_cnt_en;
  logic                w_accept;
  logic [addr_bw-1:0]  r_len;
  logic [7:0]          r_drain;
  logic [33:0]         r_inst;
  logic [33:0]         w_inst_nxt;
  logic [XMEM_W-1:0]   r_dxmem;

  assign w_accept    = host_valid && (r_state == S_LOAD);
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_len_ext   = cnt_t'(r_len);
  assign w_drain_ext = cnt_t'(r_drain);

  assign host_ready  = (r_state == S_LOAD);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign inst        = r_inst;
  assign D_xmem      = r_dxmem;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and command generation for the current state/count
  always_comb begin
    w_state_nxt = r_state;
    w_inst_nxt  = IDLE_INST;
    w_cnt_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_inst_nxt[B_CEN_X]         = 1'b0;
          w_inst_nxt[B_WEN_X]         = 1'b0;
          w_inst_nxt[B_AX_HI:B_AX_LO] = 11'(r_cnt);
          w_cnt_en                    = 1'b1;
          if (w_cnt_inc == w_len_ext) begin
            w_state_nxt = S_L0;
          end
        end
      end
      S_L0: begin
        // l0_wr trails each xmem read by one cycle to absorb SRAM read latency
        w_cnt_en = 1'b1;
        if (r_cnt < w_len_ext) begin
          w_inst_nxt[B_CEN_X]         = 1'b0;
          w_inst_nxt[B_AX_HI:B_AX_LO] = 11'(r_cnt);
        end
        if (r_cnt != '0) begin
          w_inst_nxt[B_L0_WR] = 1'b1;
        end
        if (r_cnt == w_len_ext) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_cnt_en            = 1'b1;
        w_inst_nxt[B_L0_RD] = 1'b1;
        w_inst_nxt[B_EXEC]  = 1'b1;
        if (w_cnt_inc == w_len_ext) begin
          w_state_nxt = (r_drain == '0) ? S_OUT : S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_cnt_en = 1'b1;
        if (w_cnt_inc == w_drain_ext) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        // pmem write trails each ofifo read by one cycle
        w_cnt_en = 1'b1;
        if (r_cnt < w_len_ext) begin
          w_inst_nxt[B_OFIFO_RD] = 1'b1;
        end
        if (r_cnt != '0) begin
          w_inst_nxt[B_ACC]           = 1'b0;
          w_inst_nxt[B_CEN_P]         = 1'b0;
          w_inst_nxt[B_WEN_P]         = 1'b0;
          w_inst_nxt[B_AP_HI:B_AP_LO] = 11'(r_cnt - 1'b1);
        end
        if (r_cnt == w_len_ext) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Counter (cleared on every state entry) and latched operation parameters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_drain <= '0;
    end else begin
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (w_cnt_en) begin
        r_cnt <= w_cnt_inc;
      end
      if ((r_state == S_IDLE) && start) begin
        r_len   <= len;
        r_drain <= drain;
      end
    end
  end

  // Registered command word and xmem write data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inst  <= IDLE_INST;
      r_dxmem <= '0;
    end else begin
      r_inst <= w_inst_nxt;
      if (w_accept) begin
        r_dxmem <= host_data;
      end
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: reset, full runs against a hand-derived
// command timeline, host stalls, len=0, start while busy, drain=0.
module tb_core_inst_seq;

  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] len;
  logic [7:0]  drain;
  logic [31:0] host_data;
  logic        host_valid;
  logic        host_ready;
  logic [33:0] inst;
  logic [31:0] D_xmem;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  core_inst_seq #(.bw(4), .row(8), .col(8), .addr_bw(11)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .drain      (drain),
    .host_data  (host_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .inst       (inst),
    .D_xmem     (D_xmem),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] xwr(input int a);
    logic [33:0] w;
    w = IDLE_INST;
    w[19] = 1'b0;
    w[18] = 1'b0;
    w[17:7] = 11'(a);
    return w;
  endfunction

  function automatic logic [31:0] word(input int k);
    logic [31:0] base;
    base = 32'h1111_1111;
    return base * 32'(k + 1);
  endfunction

  // Expected inst after the t-th edge following start acceptance, len=L>0,
  // host_valid held high throughout LOAD.
  function automatic logic [33:0] exp_cmd(input int t, input int L, input int D);
    logic [33:0] w;
    int c;
    w = IDLE_INST;
    if (t >= 2 && t <= L + 1) begin
      w = xwr(t - 2);
    end else if (t >= L + 2 && t <= 2 * L + 2) begin
      c = t - (L + 2);
      if (c < L) begin
        w[19] = 1'b0;
        w[17:7] = 11'(c);
      end
      if (c >= 1) w[2] = 1'b1;
    end else if (t >= 2 * L + 3 && t <= 3 * L + 2) begin
      w[3] = 1'b1;
      w[1] = 1'b1;
    end else if (t >= 3 * L + 3 + D && t <= 4 * L + 3 + D) begin
      c = t - (3 * L + 3 + D);
      if (c < L) w[6] = 1'b1;
      if (c >= 1) begin
        w[33] = 1'b0;
        w[32] = 1'b0;
        w[31] = 1'b0;
        w[30:20] = 11'(c - 1);
      end
    end
    return w;
  endfunction

  // Full operation from IDLE; optional stray start pulse at sample pulse_t.
  task automatic run_timeline(input string nm, input int L, input int D, input int pulse_t);
    int last;
    last = 4 * L + 4 + D;
    start = 1'b1; len = 11'(L); drain = 8'(D);
    host_valid = 1'b1; host_data = word(0);
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      chk($sformatf("%s inst t=%0d", nm, t), inst, exp_cmd(t, L, D));
      chk($sformatf("%s busy t=%0d", nm, t), busy, (t <= last - 1));
      chk($sformatf("%s done t=%0d", nm, t), done, (t == last - 1));
      chk($sformatf("%s host_ready t=%0d", nm, t), host_ready, (t <= L));
      if (t >= 2 && t <= L + 1)
        chk($sformatf("%s D_xmem t=%0d", nm, t), D_xmem, word(t - 2));
      start = (t == pulse_t);
      len = (t == pulse_t) ? 11'd3 : 11'(L);
      if (t <= L) host_data = word(t - 1);
      else host_valid = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] last_d;
    int          waited;
    int          done_cnt;

    // reset held with start/host_valid active
    reset = 1'b0; start = 1'b1; len = 11'd4; drain = 8'd3;
    host_valid = 1'b1; host_data = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    chk("rst inst", inst, IDLE_INST);
    chk("rst D_xmem", D_xmem, 32'h0);
    chk("rst host_ready", host_ready, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    reset = 1'b1; start = 1'b0; host_valid = 1'b0;
    @(negedge clk);
    chk("idle busy", busy, 1'b0);

    // full run len=4 drain=3
    run_timeline("full", 4, 3, 0);

    // async reset mid-EXEC
    start = 1'b1; len = 11'd4; drain = 8'd3; host_valid = 1'b1; host_data = word(0);
    for (int t = 1; t <= 11; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t <= 4) host_data = word(t - 1);
      else host_valid = 1'b0;
    end
    chk("pre-rst exec inst", inst, exp_cmd(11, 4, 3));
    #2 reset = 1'b0;
    #1;
    chk("midrst inst", inst, IDLE_INST);
    chk("midrst D_xmem", D_xmem, 32'h0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst host_ready", host_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post-rst inst", inst, IDLE_INST);
      chk("post-rst busy", busy, 1'b0);
    end

    // host stalls: len=3, valid pattern 1,0,0,1,0,1
    begin
      logic [5:0] pat;
      pat = 6'b101001;  // bit t-1 is host_valid during LOAD cycle t
      start = 1'b1; len = 11'd3; drain = 8'd0;
      host_valid = 1'b1; host_data = 32'hA000_0001;
      for (int t = 1; t <= 7; t++) begin
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("stall host_ready t=%0d", t), host_ready, (t <= 6));
        case (t)
          2: begin chk("stall inst t=2", inst, xwr(0)); chk("stall D t=2", D_xmem, 32'hA000_0001); end
          3: chk("stall inst t=3", inst, IDLE_INST);
          4: chk("stall inst t=4", inst, IDLE_INST);
          5: begin chk("stall inst t=5", inst, xwr(1)); chk("stall D t=5", D_xmem, 32'hA000_0004); end
          6: begin chk("stall inst t=6", inst, IDLE_INST); chk("stall D t=6", D_xmem, 32'hA000_0004); end
          7: begin chk("stall inst t=7", inst, xwr(2)); chk("stall D t=7", D_xmem, 32'hA000_0006); end
          default: ;
        endcase
        if (t <= 6) begin
          host_valid = pat[t-1];
          host_data  = 32'hA000_0000 + 32'(t);
        end else begin
          host_valid = 1'b0;
        end
      end
      last_d = D_xmem;
      waited = 0;
      done_cnt = 0;
      while (busy && waited < 40) begin
        @(negedge clk);
        waited++;
        if (done) done_cnt++;
      end
      chk("stall finish (busy)", busy, 1'b0);
      chk("stall finish cycles", 64'(waited), 64'd12);
      chk("stall done pulses", 64'(done_cnt), 64'd1);
      chk("stall D_xmem held", D_xmem, last_d);
    end

    // len=0
    start = 1'b1; len = 11'd0; drain = 8'd5;
    @(negedge clk);
    start = 1'b0;
    chk("len0 busy t=1", busy, 1'b1);
    chk("len0 done t=1", done, 1'b1);
    chk("len0 inst t=1", inst, IDLE_INST);
    chk("len0 host_ready t=1", host_ready, 1'b0);
    @(negedge clk);
    chk("len0 busy t=2", busy, 1'b0);
    chk("len0 done t=2", done, 1'b0);
    chk("len0 inst t=2", inst, IDLE_INST);

    // start pulse during EXEC is ignored (EXEC spans samples 16..22 for len=7)
    run_timeline("busy-start", 7, 2, 18);

    // drain=0, len=1
    run_timeline("drain0", 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
